o_reg_uart_tx: RTL and testbench
================================

Name: o_reg_uart_tx

Overview:
- Downstream consumer of the microcontroller's 4-bit output register `o_reg`.
- Detects every change of `o_reg` and queues the new nibble in a small FIFO.
- Transmits each queued nibble as one ASCII hex character on a UART 8N1 serial line, so program output can be logged off-chip.
- Sits beside the micro top level, clocked by the same `clk`, reset by the same synchronised reset.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per serial bit; legal range is 2 or greater.
- FIFO_DEPTH, 4: nibble queue depth; must be a power of 2 and at least 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- sync_reset  input  1  synchronous, active-high reset.
- o_reg  input  4  output register value from the microcontroller.
- tx  output  1  UART serial line; idles high.
- busy  output  1  high when the FIFO is non-empty or a frame is in progress.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of queued nibbles, excluding the one being sent.
- overflow  output  1  sticky flag: a change was dropped because the FIFO was full.

Behaviour:
- Reset (`sync_reset` = 1 at an edge):
  - `tx` = 1, `busy` = 0, `fifo_count` = 0, `overflow` = 0.
  - FSM = IDLE, `prev_o_reg` = 4'h0, FIFO pointers = 0.
  - Reset mid-frame aborts the frame immediately; `tx` is high after that edge.
- Change detect:
  - `prev_o_reg` is loaded with `o_reg` at every non-reset edge.
  - A capture occurs at edge k when `o_reg` != `prev_o_reg`; the new `o_reg` value is written to the FIFO at edge k.
  - The first non-reset edge compares against 4'h0, so a nonzero `o_reg` out of reset is captured.
- FIFO behaviour:
  - Writes and reads are in order.
  - A pop happens only in IDLE with the FIFO non-empty.
  - Push and pop at the same edge: both are performed and the count is unchanged.
  - Full with no pop at that edge: the capture is dropped and `overflow` is set to 1, held until reset.
  - Full with a pop at the same edge: the push is accepted.
- Character encoding:
  - Nibble 0-9 maps to 8'h30-8'h39.
  - Nibble A-F maps to 8'h41-8'h46 (uppercase).
- FSM states: IDLE, START, DATA, STOP; a bit counter counts 0 to CLKS_PER_BIT-1, and a bit index counts 0-7.
  - IDLE: if the FIFO is non-empty, pop at this edge, load the encoded byte into the shift register, set `tx` = 0, and go to START. Otherwise stay, with `tx` = 1.
  - START: hold `tx` = 0 for CLKS_PER_BIT cycles, then go to DATA and drive bit 0.
  - DATA: each bit is held CLKS_PER_BIT cycles, LSB first. After bit 7 completes, go to STOP with `tx` = 1.
  - STOP: hold `tx` = 1 for CLKS_PER_BIT cycles, then go to IDLE.
- Timing:
  - A frame is 10*CLKS_PER_BIT cycles of line time.
  - Back-to-back frames are separated by exactly 1 idle cycle (the IDLE pop cycle).
  - Latency: with a change captured at edge k and the FSM in IDLE with an empty FIFO, `tx` falls after edge k+1.
- `busy` = (FSM != IDLE) OR (`fifo_count` != 0). It is registered consistently, with no combinational path from `o_reg`.
- `tx` is driven from a flop, so it is glitch-free.

Optional Feature:
- Macro: O_REG_UART_TX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP.
  - It transmits one even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - The frame becomes 11*CLKS_PER_BIT cycles (8E1).
- When undefined: no PARITY state, 8N1 framing, 10*CLKS_PER_BIT cycles.

Test Plan:
- Reset hold, `o_reg` = 0 with CLKS_PER_BIT = 4 -> after release, `tx` = 1, `busy` = 0, `fifo_count` = 0, `overflow` = 0 for 100 cycles.
- Step `o_reg` 0 -> 5 -> `tx` falls 2 edges after the change, then sends 0x35 LSB first (1,0,1,0,1,1,0,0) followed by a stop bit; the frame is 40 cycles and `busy` drops afterwards.
- Step `o_reg` to A, then one cycle later to F -> two frames, 0x41 then 0x46, separated by exactly 1 idle cycle.
- CLKS_PER_BIT = 4, FIFO_DEPTH = 4: apply 6 distinct changes 1 cycle apart (3,4,5,6,7,8) -> '3' is in flight and 4,5,6,7 are queued; 8 is dropped; `overflow` = 1; output characters are '3','4','5','6','7'.
- Assert `sync_reset` during the DATA bit 3 of a frame with 2 nibbles queued -> `tx` = 1 next cycle, `fifo_count` = 0, no further frames, `overflow` cleared.
- With O_REG_UART_TX_PARITY_EN, `o_reg` -> 7 (0x37, five 1s) -> the parity bit is 1 and the frame is 44 cycles at CLKS_PER_BIT = 4.

Source files
------------

// File: rtl/o_reg_uart_tx.sv
// o_reg_uart_tx: watches the micro's 4-bit output register and logs each new
// value as one ASCII hex character ('0'-'9', 'A'-'F') on a UART line (8N1).
// Changes are queued in a small FIFO, so bursts of writes are not lost unless
// the queue overflows. Overflows are flagged by a sticky bit.
// Optional build macro O_REG_UART_TX_PARITY_EN adds an even-parity bit (8E1).
module o_reg_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          sync_reset,
  input  logic [3:0]                    o_reg,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef O_REG_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  // Nibble to uppercase ASCII hex digit.
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
`ifdef O_REG_UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif
  logic [3:0]      prev_q;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0] count_q, count_d;
  logic            ovf_q;
  logic [3:0]      mem_q [FIFO_DEPTH];

  logic            capture, full, pop, push, drop, bit_last;
  logic [7:0]      head_byte;

  // A pop frees a slot at the same edge, so a capture into a full queue is
  // still accepted when the transmitter is taking the head right now.
  assign capture   = (o_reg != prev_q);
  assign full      = (count_q == CNTW'(FIFO_DEPTH));
  assign pop       = (state_q == IDLE) && (count_q != '0);
  assign push      = capture && (!full || pop);
  assign drop      = capture && full && !pop;
  assign bit_last  = (cnt_q == CW'(CLKS_PER_BIT - 1));
  assign head_byte = hex_ascii(mem_q[rd_ptr_q]);

  // Queue occupancy next-state: simultaneous push and pop cancel.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  // Frame sequencer next-state; tx_d is registered so the line never glitches.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
`ifdef O_REG_UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (pop) begin
          shift_d = head_byte;
`ifdef O_REG_UART_TX_PARITY_EN
          par_d   = ^head_byte;
`endif
          tx_d    = 1'b0;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_last) begin
          cnt_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_last) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
`ifdef O_REG_UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef O_REG_UART_TX_PARITY_EN
      PARITY: begin
        if (bit_last) begin
          cnt_d   = '0;
          tx_d    = 1'b1;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      STOP: begin
        tx_d = 1'b1;
        if (bit_last) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // Control state: FSM, change detector, queue pointers and sticky overflow.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
      prev_q   <= 4'h0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      prev_q  <= o_reg;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (drop) ovf_q    <= 1'b1;
    end
  end

  // Data-only storage: contents are meaningless until the pointers say otherwise.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= o_reg;
    shift_q <= shift_d;
`ifdef O_REG_UART_TX_PARITY_EN
    par_q   <= par_d;
`endif
  end

  assign tx         = tx_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_o_reg_uart_tx.sv
// Directed bench for o_reg_uart_tx at CLKS_PER_BIT = 4, FIFO_DEPTH = 4.
module tb_o_reg_uart_tx;

  localparam int C   = 4;
  localparam int D   = 4;
  localparam int CNW = $clog2(D) + 1;
`ifdef O_REG_UART_TX_PARITY_EN
  localparam int FB  = 11;
`else
  localparam int FB  = 10;
`endif

  logic           clk = 1'b0;
  logic           sync_reset;
  logic [3:0]     o_reg;
  logic           tx, busy, overflow;
  logic [CNW-1:0] fifo_count;

  int n_cmp = 0;
  int n_err = 0;

  o_reg_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk        (clk),
    .sync_reset (sync_reset),
    .o_reg      (o_reg),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line level for frame bit position b (0 = start bit).
  function automatic logic exp_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
`ifdef O_REG_UART_TX_PARITY_EN
    if (b == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // Checks one whole frame cycle by cycle. skip = cycles of the frame already
  // elapsed at the current sample point (0 means wait for the start edge).
  task automatic rx_frame(input logic [7:0] d, input int skip, input string name);
    int   waited;
    int   pos;
    logic bad;
    if (skip == 0) begin
      waited = 0;
      while (tx !== 1'b0 && waited < 300) begin
        tick();
        waited++;
      end
      n_cmp++;
      if (tx !== 1'b0) begin
        n_err++;
        $display("FAIL %s_start: tx=%b required 0 within 300 cycles", name, tx);
        return;
      end
    end
    for (int b = skip / C; b < FB; b++) begin
      bad = 1'b0;
      for (int c = 0; c < C; c++) begin
        pos = b * C + c;
        if (pos >= skip) begin
          if (pos > skip) tick();
          if (tx !== exp_bit(d, b)) bad = 1'b1;
        end
      end
      n_cmp++;
      if (bad) begin
        n_err++;
        $display("FAIL %s_bit%0d: tx=%b required %b", name, b, tx, exp_bit(d, b));
      end
    end
  endtask

  task automatic test_reset();
    logic bad;
    sync_reset = 1'b1;
    o_reg      = 4'h0;
    repeat (3) tick();
    n_cmp++;
    if ({tx, busy, overflow} !== 3'b100 || fifo_count !== '0) begin
      n_err++;
      $display("FAIL reset_hold: tx=%b busy=%b ovf=%b cnt=%0d required 1 0 0 0", tx, busy, overflow, fifo_count);
    end
    sync_reset = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if ({tx, busy, overflow} !== 3'b100 || fifo_count !== '0) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_err++;
      $display("FAIL reset_idle100: tx=%b busy=%b ovf=%b cnt=%0d required 1 0 0 0", tx, busy, overflow, fifo_count);
    end
  endtask

  task automatic test_single();
    o_reg = 4'h5;
    tick();
    n_cmp++;
    if (tx !== 1'b1 || busy !== 1'b1 || fifo_count !== CNW'(1)) begin
      n_err++;
      $display("FAIL single_capture: tx=%b busy=%b cnt=%0d required 1 1 1", tx, busy, fifo_count);
    end
    tick();
    n_cmp++;
    if (tx !== 1'b0 || fifo_count !== '0) begin
      n_err++;
      $display("FAIL single_latency: tx=%b cnt=%0d required 0 0", tx, fifo_count);
    end
    rx_frame(8'h35, 0, "single_35");
    tick();
    n_cmp++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_done: tx=%b busy=%b required 1 0", tx, busy);
    end
  endtask

  task automatic test_back_to_back();
    o_reg = 4'hA;
    tick();
    o_reg = 4'hF;
    tick();
    rx_frame(8'h41, 0, "b2b_41");
    tick();
    n_cmp++;
    if (tx !== 1'b1 || fifo_count !== CNW'(1)) begin
      n_err++;
      $display("FAIL b2b_gap: tx=%b cnt=%0d required 1 1", tx, fifo_count);
    end
    tick();
    n_cmp++;
    if (tx !== 1'b0 || fifo_count !== '0) begin
      n_err++;
      $display("FAIL b2b_restart: tx=%b cnt=%0d required 0 0", tx, fifo_count);
    end
    rx_frame(8'h46, 0, "b2b_46");
    tick();
    n_cmp++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_done: tx=%b busy=%b required 1 0", tx, busy);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] ch;
    logic       bad;
    o_reg = 4'h3; tick();
    o_reg = 4'h4; tick();
    o_reg = 4'h5; tick();
    o_reg = 4'h6; tick();
    o_reg = 4'h7; tick();
    o_reg = 4'h8; tick();
    n_cmp++;
    if (fifo_count !== CNW'(4) || overflow !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_state: cnt=%0d ovf=%b busy=%b required 4 1 1", fifo_count, overflow, busy);
    end
    rx_frame(8'h33, 4, "ovf_33");
    for (int k = 0; k < 4; k++) begin
      ch = 8'h34 + 8'(k);
      tick();
      n_cmp++;
      if (tx !== 1'b1) begin
        n_err++;
        $display("FAIL ovf_gap%0d: tx=%b required 1", k, tx);
      end
      rx_frame(ch, 0, "ovf_chr");
    end
    tick();
    n_cmp++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== '0 || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_done: tx=%b busy=%b cnt=%0d ovf=%b required 1 0 0 1", tx, busy, fifo_count, overflow);
    end
    bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx !== 1'b1) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_err++;
      $display("FAIL ovf_dropped8: tx=%b required 1 (no sixth frame)", tx);
    end
  endtask

  task automatic test_reset_midframe();
    logic bad;
    o_reg = 4'h1; tick();
    o_reg = 4'h2; tick();
    o_reg = 4'h3; tick();
    repeat (16) tick();
    n_cmp++;
    if (tx !== 1'b0 || fifo_count !== CNW'(2) || busy !== 1'b1) begin
      n_err++;
      $display("FAIL mid_bit3: tx=%b cnt=%0d busy=%b required 0 2 1", tx, fifo_count, busy);
    end
    sync_reset = 1'b1;
    o_reg      = 4'h0;
    tick();
    n_cmp++;
    if (tx !== 1'b1 || fifo_count !== '0 || busy !== 1'b0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: tx=%b cnt=%0d busy=%b ovf=%b required 1 0 0 0", tx, fifo_count, busy, overflow);
    end
    sync_reset = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_err++;
      $display("FAIL mid_noframes: tx=%b busy=%b required 1 0", tx, busy);
    end
  endtask

`ifdef O_REG_UART_TX_PARITY_EN
  task automatic test_parity();
    o_reg = 4'h7;
    tick();
    tick();
    n_cmp++;
    if (tx !== 1'b0) begin
      n_err++;
      $display("FAIL par_latency: tx=%b required 0", tx);
    end
    rx_frame(8'h37, 0, "par_37");
    tick();
    n_cmp++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL par_done: tx=%b busy=%b required 1 0", tx, busy);
    end
  endtask
`endif

  initial begin
    sync_reset = 1'b1;
    o_reg      = 4'h0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_midframe();
`ifdef O_REG_UART_TX_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
